// File: rtl/speed_controller_pkg.sv
// Shared types and default constants for the button-driven rate controller.
package speed_controller_pkg;

    localparam int FACTOR_W = 5;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_t;

    localparam logic [FACTOR_W-1:0] FACTOR_MIN_DEF   = 5'd1;
    localparam logic [FACTOR_W-1:0] FACTOR_MAX_DEF   = 5'd31;
    localparam logic [FACTOR_W-1:0] FACTOR_RESET_DEF = 5'd24;

    // Counter width for a count of n cycles; a one-cycle count still needs one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw push-button to clean level: 2-flop synchronizer, stability debounce,
// and a one-cycle press pulse on the rising edge of the debounced level.
module button_conditioner
    import speed_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int            CW       = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_deb;
    logic          r_deb_d;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_deb_d <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            r_press <= r_deb & ~r_deb_d;
            // Any sample agreeing with the accepted level restarts the stability window.
            if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_deb;
    assign o_press = r_press;

endmodule

// File: rtl/speed_controller.sv
// Button-driven rate controller: saturating 5-bit division factor with
// auto-repeat on up/down, and a RUN/PAUSED toggle gating the counter.
module speed_controller
    import speed_controller_pkg::*;
#(
    parameter int                  DEBOUNCE_CYCLES = 1000000,
    parameter int                  REPEAT_DELAY    = 50000000,
    parameter int                  REPEAT_PERIOD   = 20000000,
    parameter logic [FACTOR_W-1:0] FACTOR_MIN      = FACTOR_MIN_DEF,
    parameter logic [FACTOR_W-1:0] FACTOR_MAX      = FACTOR_MAX_DEF,
    parameter logic [FACTOR_W-1:0] FACTOR_RESET    = FACTOR_RESET_DEF
) (
    input  logic                speed_controller_clk,
    input  logic                speed_controller_rst,
    input  logic                speed_controller_btn_up,
    input  logic                speed_controller_btn_down,
    input  logic                speed_controller_btn_pause,
    output logic [FACTOR_W-1:0] speed_controller_factor,
    output logic                speed_controller_run,
    output logic                speed_controller_factor_stb,
    output logic                speed_controller_state
);

    localparam int            RW      = cnt_w((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    logic w_up_level;
    logic w_up_press;
    logic w_dn_level;
    logic w_dn_press;
    logic w_unused_pause_level;
    logic w_pause_press;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_up (
        .i_clk   (speed_controller_clk),
        .i_rst   (speed_controller_rst),
        .i_btn   (speed_controller_btn_up),
        .o_level (w_up_level),
        .o_press (w_up_press)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_down (
        .i_clk   (speed_controller_clk),
        .i_rst   (speed_controller_rst),
        .i_btn   (speed_controller_btn_down),
        .o_level (w_dn_level),
        .o_press (w_dn_press)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_pause (
        .i_clk   (speed_controller_clk),
        .i_rst   (speed_controller_rst),
        .i_btn   (speed_controller_btn_pause),
        .o_level (w_unused_pause_level),
        .o_press (w_pause_press)
    );

    // Auto-repeat: armed by the press pulse, fires when the down-counter hits zero.
    logic [RW-1:0] r_up_rcnt;
    logic          r_up_armed;
    logic [RW-1:0] r_dn_rcnt;
    logic          r_dn_armed;
    logic          w_up_rep;
    logic          w_dn_rep;

    always_ff @(posedge speed_controller_clk) begin
        if (speed_controller_rst || !w_up_level) begin
            r_up_rcnt  <= '0;
            r_up_armed <= 1'b0;
        end else if (w_up_press) begin
            r_up_rcnt  <= RD_LAST;
            r_up_armed <= 1'b1;
        end else if (r_up_armed) begin
            r_up_rcnt  <= (r_up_rcnt == '0) ? RP_LAST : r_up_rcnt - RW'(1);
        end
    end

    always_ff @(posedge speed_controller_clk) begin
        if (speed_controller_rst || !w_dn_level) begin
            r_dn_rcnt  <= '0;
            r_dn_armed <= 1'b0;
        end else if (w_dn_press) begin
            r_dn_rcnt  <= RD_LAST;
            r_dn_armed <= 1'b1;
        end else if (r_dn_armed) begin
            r_dn_rcnt  <= (r_dn_rcnt == '0) ? RP_LAST : r_dn_rcnt - RW'(1);
        end
    end

    assign w_up_rep = w_up_level & r_up_armed & (r_up_rcnt == '0);
    assign w_dn_rep = w_dn_level & r_dn_armed & (r_dn_rcnt == '0);

    logic w_up_step;
    logic w_dn_step;

    assign w_up_step = w_up_press | w_up_rep;
    assign w_dn_step = w_dn_press | w_dn_rep;

    state_t                r_state;
    state_t                w_state_next;
    logic [FACTOR_W-1:0]   r_factor;
    logic [FACTOR_W-1:0]   w_factor_next;
    logic                  r_run;
    logic                  r_chg;
    logic                  r_stb;

    always_comb begin
        w_state_next  = r_state;
        w_factor_next = r_factor;
        // Opposing steps in one cycle cancel; limits saturate without wrap.
        if (w_up_step && !w_dn_step && (r_factor > FACTOR_MIN)) begin
            w_factor_next = r_factor - 5'd1;
        end else if (w_dn_step && !w_up_step && (r_factor < FACTOR_MAX)) begin
            w_factor_next = r_factor + 5'd1;
        end
        if (w_pause_press) begin
            w_state_next = (r_state == ST_RUN) ? ST_PAUSED : ST_RUN;
        end
    end

    always_ff @(posedge speed_controller_clk) begin
        if (speed_controller_rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // r_chg marks the cycle the new factor appears; the strobe follows one cycle later.
    always_ff @(posedge speed_controller_clk) begin
        if (speed_controller_rst) begin
            r_factor <= FACTOR_RESET;
            r_run    <= 1'b1;
            r_chg    <= 1'b0;
            r_stb    <= 1'b0;
        end else begin
            r_factor <= w_factor_next;
            r_run    <= (w_state_next == ST_RUN);
            r_chg    <= (w_factor_next != r_factor);
            r_stb    <= r_chg;
        end
    end

    assign speed_controller_factor     = r_factor;
    assign speed_controller_run        = r_run;
    assign speed_controller_factor_stb = r_stb;
    assign speed_controller_state      = r_state;

endmodule

// File: tb/tb_speed_controller.sv
// Directed bench for speed_controller with short debounce/repeat parameters.
module tb_speed_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       up;
    logic       dn;
    logic       pa;

    logic [4:0] f1, f2;
    logic       run1, run2, stb1, stb2, st1, st2;

    int n_checks = 0;
    int n_err    = 0;
    int stb1_cnt = 0;
    int stb2_cnt = 0;
    int base;

    always #5 clk = ~clk;

    speed_controller #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
    ) dut (
        .speed_controller_clk        (clk),
        .speed_controller_rst        (rst),
        .speed_controller_btn_up     (up),
        .speed_controller_btn_down   (dn),
        .speed_controller_btn_pause  (pa),
        .speed_controller_factor     (f1),
        .speed_controller_run        (run1),
        .speed_controller_factor_stb (stb1),
        .speed_controller_state      (st1)
    );

    speed_controller #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(4), .FACTOR_RESET(5'd3)
    ) dut_low (
        .speed_controller_clk        (clk),
        .speed_controller_rst        (rst),
        .speed_controller_btn_up     (up),
        .speed_controller_btn_down   (dn),
        .speed_controller_btn_pause  (pa),
        .speed_controller_factor     (f2),
        .speed_controller_run        (run2),
        .speed_controller_factor_stb (stb2),
        .speed_controller_state      (st2)
    );

    always @(negedge clk) begin
        if (stb1 === 1'b1) stb1_cnt++;
        if (stb2 === 1'b1) stb2_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
    endtask

    initial begin
        up = 1'b0; dn = 1'b0; pa = 1'b0; rst = 1'b1;
        step(3);
        check("rst_factor", 32'(f1), 24);
        check("rst_run", 32'(run1), 1);
        check("rst_state", 32'(st1), 0);
        check("rst_stb", 32'(stb1), 0);
        check("rst_factor_low", 32'(f2), 3);
        rst = 1'b0;
        step(2);

        // single up press: factor 24 -> 23 at cycle 8, strobe at cycle 9
        base = stb1_cnt;
        up = 1'b1;
        step(6);
        up = 1'b0;
        step(1);
        check("up_c7_factor", 32'(f1), 24);
        step(1);
        check("up_c8_factor", 32'(f1), 23);
        check("up_c8_stb", 32'(stb1), 0);
        step(1);
        check("up_c9_stb", 32'(stb1), 1);
        step(1);
        check("up_c10_stb", 32'(stb1), 0);
        step(20);
        check("up_final_factor", 32'(f1), 23);
        check("up_stb_count", 32'(stb1_cnt - base), 1);

        // bounce rejection: 3-cycle high pulses never qualify
        do_reset();
        base = stb1_cnt;
        for (int i = 0; i < 40; i++) begin
            up = ((i % 6) < 3);
            step(1);
        end
        up = 1'b0;
        step(10);
        check("bounce_factor", 32'(f1), 24);
        check("bounce_stb_count", 32'(stb1_cnt - base), 0);

        // pause toggle twice, 20 cycles apart
        base = stb1_cnt;
        pa = 1'b1;
        step(6);
        pa = 1'b0;
        step(1);
        check("pause1_c7_run", 32'(run1), 1);
        step(1);
        check("pause1_c8_run", 32'(run1), 0);
        check("pause1_c8_state", 32'(st1), 1);
        step(12);
        pa = 1'b1;
        step(6);
        pa = 1'b0;
        step(1);
        check("pause2_c27_run", 32'(run1), 0);
        step(1);
        check("pause2_c28_run", 32'(run1), 1);
        check("pause2_c28_state", 32'(st1), 0);
        step(10);
        check("pause_factor", 32'(f1), 24);
        check("pause_stb_count", 32'(stb1_cnt - base), 0);

        // up and down together cancel
        base = stb1_cnt;
        up = 1'b1; dn = 1'b1;
        step(6);
        up = 1'b0; dn = 1'b0;
        step(3);
        check("updn_factor", 32'(f1), 24);
        step(11);
        check("updn_stb_count", 32'(stb1_cnt - base), 0);

        // pause and down together both take effect
        pa = 1'b1; dn = 1'b1;
        step(6);
        pa = 1'b0; dn = 1'b0;
        step(1);
        check("padn_c7_factor", 32'(f1), 24);
        check("padn_c7_run", 32'(run1), 1);
        step(1);
        check("padn_c8_factor", 32'(f1), 25);
        check("padn_c8_run", 32'(run1), 0);
        check("padn_c8_state", 32'(st1), 1);
        step(1);
        check("padn_c9_stb", 32'(stb1), 1);
        step(20);

        // auto-repeat and saturation at the minimum
        rst = 1'b1;
        step(2);
        check("rep_rst_factor_low", 32'(f2), 3);
        check("rep_rst_run", 32'(run1), 1);
        rst = 1'b0;
        step(2);
        base = stb2_cnt;
        up = 1'b1;
        step(7);
        check("rep_c7_low", 32'(f2), 3);
        step(1);
        check("rep_c8_low", 32'(f2), 2);
        step(1);
        check("rep_c9_stb_low", 32'(stb2), 1);
        step(6);
        check("rep_c15_low", 32'(f2), 2);
        step(1);
        check("rep_c16_low", 32'(f2), 1);
        step(1);
        check("rep_c17_stb_low", 32'(stb2), 1);
        step(3);
        check("rep_c20_factor", 32'(f1), 21);
        step(40);
        check("rep_c60_low", 32'(f2), 1);
        check("rep_stb_count_low", 32'(stb2_cnt - base), 2);
        up = 1'b0;
        step(10);

        // button held across reset release needs a full fresh debounce
        up = 1'b1;
        step(5);
        rst = 1'b1;
        step(2);
        check("midrst_factor", 32'(f1), 24);
        check("midrst_stb", 32'(stb1), 0);
        rst = 1'b0;
        step(7);
        check("midrst_c7_factor", 32'(f1), 24);
        step(1);
        check("midrst_c8_factor", 32'(f1), 23);
        up = 1'b0;
        step(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/speed_controller.md
# speed_controller

Button-driven rate controller for the two-digit counter. It conditions three raw push-buttons (up, down, pause) and maintains the 5-bit division factor that feeds the clock manager. It also gates the counter through a run enable, with saturating factor steps and auto-repeat while up/down is held. It sits between the board buttons and the clock manager / counter enable, in the system clock domain.

## Interface
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before a button level is accepted (10 ms at 100 MHz)
- REPEAT_DELAY, 50000000, cycles a debounced up/down must stay held after its press pulse before the first auto-repeat step
- REPEAT_PERIOD, 20000000, cycles between subsequent auto-repeat steps
- FACTOR_MIN, 5'd1, lowest factor (fastest output clock)
- FACTOR_MAX, 5'd31, highest factor (slowest output clock)
- FACTOR_RESET, 5'd24, factor loaded by reset
- speed_controller_clk  input  1  system clock; all logic on rising edge
- speed_controller_rst  input  1  synchronous, active-high reset
- speed_controller_btn_up  input  1  raw, asynchronous; press = 1; decrements factor (faster)
- speed_controller_btn_down  input  1  raw, asynchronous; press = 1; increments factor (slower)
- speed_controller_btn_pause  input  1  raw, asynchronous; press toggles RUN/PAUSED
- speed_controller_factor  output  5  factor to clock manager; registered
- speed_controller_run  output  1  counter enable; 1 in RUN, 0 in PAUSED; registered
- speed_controller_factor_stb  output  1  one-cycle pulse in the cycle after factor changes
- speed_controller_state  output  1  0 = RUN, 1 = PAUSED (LED drive)

## Operation
- Reset values: factor = FACTOR_RESET, run = 1, state = RUN, factor_stb = 0. All synchronizers, debounce counters, debounced levels (0) and repeat counters are cleared.
- Button conditioning, per button:
  - 2-flop synchronizer.
  - Debounce counter clears whenever the synced value equals the debounced level. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced value and the counter clears.
  - Rising edge of the debounced level produces a one-cycle press pulse.
- Auto-repeat (up and down only):
  - A press pulse loads the repeat counter.
  - While the debounced level stays 1, a repeat pulse fires REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles.
  - Debounced level 0 clears the counter immediately.
  - A step = press pulse OR repeat pulse.
- Factor update:
  - up step: factor <= factor-1 if factor > FACTOR_MIN.
  - down step: factor <= factor+1 if factor < FACTOR_MAX.
  - At a limit: factor unchanged, no factor_stb.
  - up and down steps in the same cycle: both ignored, no factor_stb.
  - Arithmetic is 5-bit unsigned. Wrap-around never occurs.
- Factor steps are accepted in both RUN and PAUSED.
- FSM, 2 states:
  - RUN -> PAUSED on pause press pulse; PAUSED -> RUN on pause press pulse.
  - No other transitions.
  - A pause pulse together with a step in the same cycle: both take effect.
- factor_stb = 1 exactly in the cycle after the factor register changed value.
- Reset mid-operation: the reset state wins. A button held across reset release is treated as a fresh press after a full debounce.

## Timing
- Raw edge to press pulse:
  - Raw rises and stays stable from cycle 0.
  - Synced value = 1 from cycle 2.
  - Debounced level = 1 at cycle 2+DEBOUNCE_CYCLES.
  - Press pulse at cycle 3+DEBOUNCE_CYCLES.
- Press pulse to outputs: factor/run/state update on the next edge, i.e. the new value is visible in cycle 4+DEBOUNCE_CYCLES. factor_stb is high in cycle 5+DEBOUNCE_CYCLES.
- Release uses the same debounce latency; release produces no pulse.
- Bounces shorter than DEBOUNCE_CYCLES produce no level change.
- Maximum step rate: one per REPEAT_PERIOD (≥ 2 required). The factor changes by at most 1 per cycle.

## Structure
- Shared package speed_controller_pkg:
  - FACTOR_W = 5.
  - State encoding ST_RUN = 1'b0, ST_PAUSED = 1'b1.
  - Default FACTOR_MIN/MAX/RESET constants.
- Sub-module button_conditioner (synchronizer + debounce + press pulse), parameterized by DEBOUNCE_CYCLES. It has three instances.
- Auto-repeat counters and the factor/FSM registers live in speed_controller.
- Counter widths are $clog2 of the respective parameter.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4.
- Reset:
  - Stimulus: hold rst 3 cycles.
  - Required: factor=24, run=1, state=0, factor_stb=0.
- Single up press:
  - Stimulus: up held 1 for 6 cycles, then released.
  - Required: factor=23 visible in cycle 8, factor_stb high in cycle 9, no further change.
- Bounce rejection:
  - Stimulus: up toggles 1/0 with 3-cycle high pulses for 40 cycles.
  - Required: factor stays 24, factor_stb never asserted.
- Auto-repeat and saturation:
  - Stimulus: reset with FACTOR_RESET=3, hold up 60 cycles.
  - Required: factor 3->2 at the press, 2->1 eight cycles later, then stays 1 with no further factor_stb.
- Pause toggle:
  - Stimulus: pause pressed twice, separated by 20 cycles.
  - Required: run=0/state=1 after the first press, run=1/state=0 after the second, factor unchanged.
- Simultaneous events:
  - Stimulus: up and down rise in the same cycle, then pause + down in the same cycle.
  - Required: the first gives factor 24 unchanged and no factor_stb; the second gives factor 25 and run=0 together.
